// File: rtl/aes_engine_scheduler.sv
// aes_engine_scheduler
// Two requesters share one encrypt_engine. This block arbitrates between
// them round-robin, re-keys the engine when the granted requester's key
// differs from the loaded key, and drains the pipeline before each re-key.
// Completed ciphertexts return on one tagged response bus.
//
// Ports
//   clk, rst                     clock, synchronous active-high reset
//   req_valid[1:0]/req_ready     per-requester handshake (ready is combinational)
//   req_block0/1, req_key0/1     plaintext and AES-128 key per requester
//   flush                        abort all in-flight work (one-cycle engine halt)
//   resp_valid/resp_id/resp_data tagged ciphertext response, no backpressure
//   eng_start/eng_set_key/eng_halt, eng_state/eng_key   engine controls and data
//   eng_out_valid/eng_out        engine results, returned in issue order
//   busy                         not IDLE, or blocks still in the engine
//   err                          sticky: engine result arrived with no tag pending
module aes_engine_scheduler #(
  parameter int unsigned KEY_LAT      = 10,
  parameter int unsigned MAX_INFLIGHT = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [1:0]   req_valid,
  output logic [1:0]   req_ready,
  input  logic [127:0] req_block0,
  input  logic [127:0] req_block1,
  input  logic [127:0] req_key0,
  input  logic [127:0] req_key1,
  input  logic         flush,
  output logic         resp_valid,
  output logic         resp_id,
  output logic [127:0] resp_data,
  output logic         eng_start,
  output logic         eng_set_key,
  output logic         eng_halt,
  output logic [127:0] eng_state,
  output logic [127:0] eng_key,
  input  logic         eng_out_valid,
  input  logic [127:0] eng_out,
  output logic         busy,
  output logic         err
);

  localparam int unsigned PW = (MAX_INFLIGHT > 1) ? $clog2(MAX_INFLIGHT) : 1;
  localparam int unsigned CW = $clog2(MAX_INFLIGHT + 1);
  localparam int unsigned KW = (KEY_LAT > 1) ? $clog2(KEY_LAT + 1) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_LOAD,
    S_KEYWAIT,
    S_HALT
  } state_t;

  state_t          r_state, w_next;
  logic [127:0]    r_cur_key;
  logic            r_key_ok;
  logic            r_rr_ptr;
  logic            r_lock_id;
  logic            r_force;
  logic [CW-1:0]   r_inflight;
  logic            r_tag [0:MAX_INFLIGHT-1];
  logic [PW-1:0]   r_wr_ptr, r_rd_ptr;
  logic [KW-1:0]   r_kw_cnt;

  logic            r_eng_start, r_eng_set_key, r_eng_halt;
  logic [127:0]    r_eng_state, r_eng_key;
  logic            r_resp_valid, r_resp_id;
  logic [127:0]    r_resp_data;
  logic            r_err;

  logic            w_arb, w_any, w_win, w_key_hit, w_room, w_grant;
  logic            w_empty, w_resp_en, w_pop, w_spurious, w_lock_set;
  logic [127:0]    w_win_key, w_win_blk, w_lock_key;

  function automatic logic [PW-1:0] f_inc(input logic [PW-1:0] p);
    return (p == PW'(MAX_INFLIGHT - 1)) ? '0 : p + PW'(1);
  endfunction

  // Arbitration
  always_comb begin
    w_any = |req_valid;
    w_arb = ((r_state == S_IDLE) || (r_state == S_RUN)) && !flush;
    // Right after a re-key the locked requester goes first so the other
    // requester cannot immediately force yet another key switch.
    if (r_force && req_valid[r_lock_id])
      w_win = r_lock_id;
    else if (&req_valid)
      w_win = r_rr_ptr;
    else
      w_win = req_valid[1];
    w_win_key  = w_win ? req_key1 : req_key0;
    w_win_blk  = w_win ? req_block1 : req_block0;
    w_lock_key = r_lock_id ? req_key1 : req_key0;
    w_key_hit  = r_key_ok && (w_win_key == r_cur_key);
    w_room     = r_inflight < CW'(MAX_INFLIGHT);
    w_grant    = w_arb && w_any && w_key_hit && w_room;
    // A full pipeline with a matching key just waits; only a key mismatch drains.
    w_lock_set = w_arb && w_any && !w_key_hit;
    req_ready  = '0;
    if (w_grant)
      req_ready[w_win] = 1'b1;
  end

  // Response path: results in the flush cycle and the HALT cycle are dropped.
  always_comb begin
    w_empty    = (r_inflight == '0);
    w_resp_en  = eng_out_valid && !flush && (r_state != S_HALT);
    w_pop      = w_resp_en && !w_empty;
    w_spurious = w_resp_en && w_empty;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_RUN: begin
        if (w_lock_set)
          w_next = S_DRAIN;
        else if (w_any || !w_empty)
          w_next = S_RUN;
        else
          w_next = S_IDLE;
      end
      S_DRAIN:   if (w_empty) w_next = S_LOAD;
      S_LOAD:    w_next = S_KEYWAIT;
      S_KEYWAIT: if (r_kw_cnt <= KW'(1)) w_next = S_RUN;
      S_HALT:    w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
    if (flush)
      w_next = S_HALT;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_cur_key     <= '0;
      r_key_ok      <= 1'b0;
      r_rr_ptr      <= 1'b0;
      r_lock_id     <= 1'b0;
      r_force       <= 1'b0;
      r_inflight    <= '0;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_kw_cnt      <= '0;
      r_eng_start   <= 1'b0;
      r_eng_set_key <= 1'b0;
      r_eng_halt    <= 1'b0;
      r_eng_state   <= '0;
      r_eng_key     <= '0;
      r_resp_valid  <= 1'b0;
      r_resp_id     <= 1'b0;
      r_resp_data   <= '0;
      r_err         <= 1'b0;
      for (int unsigned i = 0; i < MAX_INFLIGHT; i++)
        r_tag[i] <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_eng_start <= w_grant;
      r_eng_halt  <= flush;

      if (w_grant) begin
        r_eng_state       <= w_win_blk;
        r_eng_key         <= r_cur_key;
        r_rr_ptr          <= ~w_win;
        r_tag[r_wr_ptr]   <= w_win;
        r_wr_ptr          <= f_inc(r_wr_ptr);
      end
      if (w_lock_set)
        r_lock_id <= w_win;

      // The set_key pulse is registered, so it is issued on leaving DRAIN
      // and is visible to the engine during the LOAD cycle.
      r_eng_set_key <= (r_state == S_DRAIN) && (w_next == S_LOAD);
      if ((r_state == S_DRAIN) && (w_next == S_LOAD)) begin
        r_eng_key <= w_lock_key;
        r_cur_key <= w_lock_key;
      end

      if (r_state == S_LOAD) begin
        r_kw_cnt <= KW'(KEY_LAT);
        r_key_ok <= 1'b0;
      end else if (r_state == S_KEYWAIT) begin
        r_kw_cnt <= r_kw_cnt - KW'(1);
      end

      if ((r_state == S_KEYWAIT) && (w_next == S_RUN)) begin
        r_key_ok <= 1'b1;
        r_force  <= 1'b1;
      end else if ((r_state == S_IDLE) || (r_state == S_RUN)) begin
        r_force  <= 1'b0;
      end

      if (w_pop)
        r_rd_ptr <= f_inc(r_rd_ptr);
      case ({w_grant, w_pop})
        2'b10:   r_inflight <= r_inflight + CW'(1);
        2'b01:   r_inflight <= r_inflight - CW'(1);
        default: r_inflight <= r_inflight;
      endcase

      r_resp_valid <= w_pop;
      if (w_pop) begin
        r_resp_id   <= r_tag[r_rd_ptr];
        r_resp_data <= eng_out;
      end
      if (w_spurious)
        r_err <= 1'b1;

      if (flush) begin
        r_inflight <= '0;
        r_wr_ptr   <= '0;
        r_rd_ptr   <= '0;
        r_key_ok   <= 1'b0;
        r_force    <= 1'b0;
      end
    end
  end

  always_comb begin
    eng_start   = r_eng_start;
    eng_set_key = r_eng_set_key;
    eng_halt    = r_eng_halt;
    eng_state   = r_eng_state;
    eng_key     = r_eng_key;
    resp_valid  = r_resp_valid;
    resp_id     = r_resp_id;
    resp_data   = r_resp_data;
    err         = r_err;
    busy        = (r_state != S_IDLE) || !w_empty;
  end

endmodule
